// File: rtl/draw_rect.sv
// Rectangle blitter: copies a rect_w x rect_h block from a linear source image
// into a SCREEN_W x SCREEN_H frame buffer, one pixel per READ/WAIT/WRITE pass.
module draw_rect #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 24,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [8:0]        dst_x,
    input  logic [7:0]        dst_y,
    input  logic [8:0]        rect_w,
    input  logic [7:0]        rect_h,
    input  logic [ADDR_W-1:0] src_base,
    input  logic              transp_en,
    input  logic [DATA_W-1:0] transp_key,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic              frame_buf_we,
    output logic [ADDR_W-1:0] frame_buf_addr,
    output logic [DATA_W-1:0] frame_buf_data,
    output logic              done,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    localparam logic [9:0] SCREEN_W_C = 10'(SCREEN_W);
    localparam logic [8:0] SCREEN_H_C = 9'(SCREEN_H);
    localparam logic [1:0] WAIT_LAST  = 2'((READ_LAT > 1) ? READ_LAT - 2 : 0);

    state_e              state_q, state_d;
    logic [8:0]          x_q, x_d;
    logic [7:0]          y_q, y_d;
    logic [8:0]          w_q, w_d;
    logic [7:0]          h_q, h_d;
    logic                ten_q, ten_d;
    logic [DATA_W-1:0]   key_q, key_d;
    logic [8:0]          col_q, col_d;
    logic [7:0]          row_q, row_d;
    logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
    logic [1:0]          wait_cnt_q, wait_cnt_d;

    logic [9:0] px;
    logic [8:0] py;
    logic       clipped;
    logic       transparent;
    logic       last_col;
    logic       last_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            ten_q      <= 1'b0;
            key_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            src_addr_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            ten_q      <= ten_d;
            key_q      <= key_d;
            col_q      <= col_d;
            row_q      <= row_d;
            src_addr_q <= src_addr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Destination coordinates are widened so off-screen pixels compare correctly.
    assign px          = {1'b0, x_q} + {1'b0, col_q};
    assign py          = {1'b0, y_q} + {1'b0, row_q};
    assign clipped     = (px >= SCREEN_W_C) || (py >= SCREEN_H_C);
    assign transparent = ten_q && (src_data == key_q);
    assign last_col    = (col_q == w_q - 9'd1);
    assign last_row    = (row_q == h_q - 8'd1);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        ten_d      = ten_q;
        key_d      = key_q;
        col_d      = col_q;
        row_d      = row_q;
        src_addr_d = src_addr_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    x_d        = dst_x;
                    y_d        = dst_y;
                    w_d        = rect_w;
                    h_d        = rect_h;
                    ten_d      = transp_en;
                    key_d      = transp_key;
                    col_d      = '0;
                    row_d      = '0;
                    src_addr_d = src_base;
                    if (rect_w != 9'd0 && rect_h != 8'd0) begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (READ_LAT > 1) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_WRITE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_WRITE: begin
                // Source address is a running counter: row*w+col advances by one per pixel.
                src_addr_d = src_addr_q + 1'b1;
                if (last_col) begin
                    col_d = '0;
                    row_d = row_q + 8'd1;
                end else begin
                    col_d = col_q + 9'd1;
                end
                if (abort || (last_col && last_row)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign done           = (state_q == S_IDLE);
    assign src_addr       = src_addr_q;
    assign frame_buf_data = src_data;
    assign frame_buf_addr = ADDR_W'(py) * ADDR_W'(SCREEN_W) + ADDR_W'(px);
    assign frame_buf_we   = (state_q == S_WRITE) && !clipped && !transparent;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_draw_rect.sv
// Directed bench for draw_rect: a vector table of rectangles at READ_LAT=1, plus
// hand sequences for READ_LAT=3 spacing, abort, ignored starts and mid-draw reset.
module tb_draw_rect;

    localparam int AW = 17;
    localparam int DW = 24;

    typedef struct {
        int          dx;
        int          dy;
        int          w;
        int          h;
        int          base;
        bit          ten;
        logic [23:0] key;
        int          exp_wr;
        int          exp_cyc;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_a, start_b, abort;
    logic [8:0]    dst_x;
    logic [7:0]    dst_y;
    logic [8:0]    rect_w;
    logic [7:0]    rect_h;
    logic [AW-1:0] src_base;
    logic          transp_en;
    logic [DW-1:0] transp_key;

    logic [AW-1:0] a_src, b_src, a_fb_addr, b_fb_addr;
    logic [DW-1:0] a_src_data, b_src_data, a_fb_data, b_fb_data, b_p1, b_p2;
    logic          a_we, b_we, a_done, b_done;
    logic [1:0]    a_state, b_state;

    logic [DW-1:0] mem [0:4095];
    logic [AW+DW-1:0] exp_a_q[$];
    logic [AW+DW-1:0] exp_b_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int a_wr_n = 0;
    int b_wr_n = 0;
    int b_last = 0;

    always #5 clk = ~clk;

    draw_rect #(.READ_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .dst_x(dst_x), .dst_y(dst_y), .rect_w(rect_w), .rect_h(rect_h),
        .src_base(src_base), .transp_en(transp_en), .transp_key(transp_key),
        .src_addr(a_src), .src_data(a_src_data),
        .frame_buf_we(a_we), .frame_buf_addr(a_fb_addr), .frame_buf_data(a_fb_data),
        .done(a_done), .dbg_state_o(a_state)
    );

    draw_rect #(.READ_LAT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .dst_x(dst_x), .dst_y(dst_y), .rect_w(rect_w), .rect_h(rect_h),
        .src_base(src_base), .transp_en(transp_en), .transp_key(transp_key),
        .src_addr(b_src), .src_data(b_src_data),
        .frame_buf_we(b_we), .frame_buf_addr(b_fb_addr), .frame_buf_data(b_fb_data),
        .done(b_done), .dbg_state_o(b_state)
    );

    // Source memory models with one- and three-cycle read latency.
    always @(posedge clk) begin
        a_src_data <= mem[a_src[11:0]];
        b_p1       <= mem[b_src[11:0]];
        b_p2       <= b_p1;
        b_src_data <= b_p2;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Advance one clock and score any frame-buffer write at the falling edge.
    task automatic step();
        logic [AW+DW-1:0] e;
        @(negedge clk);
        cyc++;
        if (a_we) begin
            a_wr_n++;
            if (exp_a_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_write: got %0h required no write", {a_fb_addr, a_fb_data});
            end else begin
                e = exp_a_q.pop_front();
                chk("a_write", {a_fb_addr, a_fb_data}, e);
            end
        end
        if (b_we) begin
            if (b_wr_n > 0) chk("b_spacing", cyc - b_last, 4);
            b_last = cyc;
            b_wr_n++;
            if (exp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_write: got %0h required no write", {b_fb_addr, b_fb_data});
            end else begin
                e = exp_b_q.pop_front();
                chk("b_write", {b_fb_addr, b_fb_data}, e);
            end
        end
    endtask

    // Reference model: walk the rectangle and queue the writes that should land.
    task automatic build_exp(input vec_t v, input int max_n, input bit to_b);
        int n;
        int a, px, py;
        logic [AW-1:0] a17;
        logic [DW-1:0] d;
        n = 0;
        for (int r = 0; r < v.h; r++) begin
            for (int c = 0; c < v.w; c++) begin
                a   = v.base + r * v.w + c;
                a17 = AW'(a);
                d   = mem[a17[11:0]];
                px  = v.dx + c;
                py  = v.dy + r;
                if (px < 320 && py < 240 && !(v.ten && d == v.key) && n < max_n) begin
                    n++;
                    if (to_b) exp_b_q.push_back({AW'(py * 320 + px), d});
                    else      exp_a_q.push_back({AW'(py * 320 + px), d});
                end
            end
        end
    endtask

    task automatic drive(input vec_t v);
        dst_x      = 9'(v.dx);
        dst_y      = 8'(v.dy);
        rect_w     = 9'(v.w);
        rect_h     = 8'(v.h);
        src_base   = AW'(v.base);
        transp_en  = v.ten;
        transp_key = v.key;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n, w0;
        build_exp(v, 1 << 30, 1'b0);
        w0 = a_wr_n;
        drive(v);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 0;
        while (!a_done && n < 5000) begin
            step();
            n++;
        end
        chk({tag, "_cycles"}, n, v.exp_cyc);
        chk({tag, "_writes"}, a_wr_n - w0, v.exp_wr);
        chk({tag, "_pending"}, exp_a_q.size(), 0);
        exp_a_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vec_t v;
        int   n, w0;
        bit   injected;

        for (int i = 0; i < 4096; i++) begin
            mem[i] = {12'(i) ^ 12'hA5C, 12'(i)};
        end
        mem[2000] = 24'hFF00FF;
        mem[2001] = 24'h123456;
        mem[2002] = 24'hFF00FF;
        mem[2003] = 24'hABCDEF;

        //          dx   dy   w   h   base    ten key         writes cycles
        vecs[0] = '{0,   0,   64, 8,  0,      0, 24'h0,       512, 1024};
        vecs[1] = '{316, 238, 8,  4,  100,    0, 24'h0,       8,   64};
        vecs[2] = '{10,  5,   4,  1,  2000,   1, 24'hFF00FF,  2,   8};
        vecs[3] = '{10,  5,   4,  1,  2000,   0, 24'hFF00FF,  4,   8};
        vecs[4] = '{5,   7,   3,  2,  131070, 0, 24'h0,       6,   12};
        vecs[5] = '{319, 239, 1,  1,  9,      0, 24'h0,       1,   2};
        vecs[6] = '{320, 0,   2,  2,  40,     0, 24'h0,       0,   8};
        vecs[7] = '{0,   0,   0,  5,  0,      0, 24'h0,       0,   0};
        vecs[8] = '{3,   3,   4,  0,  0,      0, 24'h0,       0,   0};
        vecs[9] = '{0,   230, 2,  12, 500,    0, 24'h0,       20,  48};

        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        abort = 1'b0;
        drive(vecs[7]);
        step();
        step();
        chk("rst_done_a", a_done, 1);
        chk("rst_we_a", a_we, 0);
        chk("rst_src_a", a_src, 0);
        chk("rst_fba_a", a_fb_addr, 0);
        chk("rst_state_a", a_state, 0);
        chk("rst_done_b", b_done, 1);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Start and abort together in IDLE: abort wins.
        drive(vecs[5]);
        start_a = 1'b1;
        abort = 1'b1;
        step();
        start_a = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", a_done, 1);

        // READ_LAT=3, 2x2: writes four cycles apart with data from three cycles back.
        v = '{2, 3, 2, 2, 50, 0, 24'h0, 4, 16};
        build_exp(v, 1 << 30, 1'b1);
        drive(v);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("b_state_read", b_state, 1);
        step();
        chk("b_state_wait", b_state, 2);
        n = 1;
        while (!b_done && n < 200) begin
            step();
            n++;
        end
        chk("b_cycles", n, 16);
        chk("b_writes", b_wr_n, 4);
        chk("b_pending", exp_b_q.size(), 0);

        // Abort on the 10th write of a 16x16 draw; a start mid-draw is ignored.
        v = '{20, 30, 16, 16, 300, 0, mem[305], 0, 0};
        build_exp(v, 10, 1'b0);
        w0 = a_wr_n;
        drive(v);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 0;
        injected = 1'b0;
        while (a_wr_n - w0 < 10 && n < 2000) begin
            step();
            n++;
            if (!injected && a_wr_n - w0 == 3) begin
                injected = 1'b1;
                start_a = 1'b1;
                drive('{0, 0, 1, 1, 0, 1, mem[305], 0, 0});
            end else begin
                start_a = 1'b0;
            end
        end
        start_a = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", a_done, 1);
        for (int i = 0; i < 20; i++) step();
        chk("abort_writes", a_wr_n - w0, 10);
        chk("abort_pending", exp_a_q.size(), 0);
        exp_a_q.delete();
        run_vec(vecs[7], "zero_after_abort");

        // Reset pulsed during the 5th write of a draw.
        v = '{40, 50, 16, 16, 600, 0, 24'h0, 0, 0};
        build_exp(v, 5, 1'b0);
        w0 = a_wr_n;
        drive(v);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 0;
        while (a_wr_n - w0 < 5 && n < 2000) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", a_we, 0);
        chk("mid_rst_done", a_done, 1);
        chk("mid_rst_src", a_src, 0);
        chk("mid_rst_fba", a_fb_addr, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", a_state, 0);
        chk("post_rst_done", a_done, 1);
        chk("mid_rst_writes", a_wr_n - w0, 5);
        chk("mid_rst_pending", exp_a_q.size(), 0);
        exp_a_q.delete();
        run_vec('{0, 0, 3, 2, 7, 0, 24'h0, 6, 12}, "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/draw_rect.md
DRAW_RECT -- requirements
Module: draw_rect

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320, frame buffer width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 240, frame buffer height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 17, frame buffer and source address width.
REQ-004 SHALL have parameter DATA_W, default 24, pixel width.
REQ-005 SHALL have parameter READ_LAT, default 1 (legal 1..4), source memory read latency in cycles.
REQ-006 SHALL have ports: clk  in  1  system clock, rising edge; rst_n  in  1  reset.
REQ-007 The reset SHALL be asynchronous and active-low, on the single clock clk.
REQ-008 SHALL have ports: start  in  1  begin a draw; abort  in  1  cancel the draw in progress.
REQ-009 SHALL have ports: dst_x  in  9 and dst_y  in  8, top-left destination pixel.
REQ-010 SHALL have ports: rect_w  in  9 and rect_h  in  8, rectangle size in pixels.
REQ-011 SHALL have ports: src_base  in  ADDR_W  source image start address; transp_en  in  1; transp_key  in  DATA_W  transparent color.
REQ-012 SHALL have ports: src_addr  out  ADDR_W; src_data  in  DATA_W  source memory read data.
REQ-013 SHALL have ports: frame_buf_we  out  1; frame_buf_addr  out  ADDR_W; frame_buf_data  out  DATA_W.
REQ-014 SHALL have port: done  out  1  high when idle.

Function
REQ-015 States SHALL be IDLE, READ, WAIT, WRITE; WAIT is used only when READ_LAT>1.
REQ-016 IDLE: done=1, frame_buf_we=0; start=1 SHALL latch dst_x, dst_y, rect_w, rect_h, src_base, transp_en and transp_key, clear the row and col counters, and go to READ.
REQ-017 start SHALL be ignored outside IDLE; latched values SHALL stay fixed for the whole draw.
REQ-018 start with rect_w=0 or rect_h=0 SHALL go to IDLE on the next cycle with no writes.
REQ-019 READ: src_addr = src_base + row*rect_w + col, kept as a running counter and wrapping modulo 2^ADDR_W.
REQ-020 READ SHALL go to WAIT when READ_LAT>1 and to WRITE otherwise.
REQ-021 WAIT SHALL last READ_LAT-1 cycles, then go to WRITE; src_addr SHALL be held through WAIT.
REQ-022 WRITE: frame_buf_data = src_data; frame_buf_addr = (dst_y+row)*SCREEN_W + (dst_x+col), computed at full width with no wrap.
REQ-023 WRITE SHALL drive frame_buf_we=1 unless the pixel is clipped or transparent.
REQ-024 A pixel is clipped when dst_x+col >= SCREEN_W or dst_y+row >= SCREEN_H; it is transparent when transp_en=1 and src_data == transp_key.
REQ-025 Suppressed pixels SHALL still consume their READ/WAIT/WRITE cycles and advance the counters.
REQ-026 After WRITE, col SHALL increment; when col = rect_w-1, col SHALL clear and row SHALL increment.
REQ-027 WRITE of the last pixel (row = rect_h-1, col = rect_w-1) SHALL go to IDLE; otherwise WRITE SHALL go to READ.
REQ-028 Each pixel SHALL take READ_LAT+1 cycles; a full 320x240 draw at READ_LAT=1 takes 153600 cycles from the start edge to done.
REQ-029 frame_buf_we SHALL be high only in WRITE and at most one cycle per pixel.
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no further writes.
REQ-031 An abort on the same cycle as a WRITE SHALL let that write complete.
REQ-032 In IDLE, abort has no effect; start and abort together in IDLE: abort wins and the block stays IDLE.
REQ-033 frame_buf_addr and src_addr SHALL be registered or derived only from registered state, with no combinational path from start.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and clear row, col and all latched registers.
REQ-035 During reset, done=1, frame_buf_we=0, src_addr=0 and frame_buf_addr=0.
REQ-036 Reset mid-draw SHALL cancel the draw without a resume; the first clock edge after release SHALL find the block in IDLE.

Verification
REQ-037 Full screen, READ_LAT=1: dst=(0,0), size 320x240, src_base=0, transp_en=0 -> 76800 writes, addresses 0..76799 in order, data equals ROM[addr], done after 153600 cycles.
REQ-038 Clipping: dst=(316,238), size 8x4 -> only the 8 pixels with x<=319 and y<=239 are written (addresses 76476..76479 and 76796..76799); total runtime 32*2 cycles.
REQ-039 Transparency: 4x1 row with source data {key, A, key, B}, transp_en=1 -> exactly 2 writes, at dst+1 and dst+3.
REQ-040 READ_LAT=3: 2x2 rectangle -> 4 writes spaced 4 cycles apart, each frame_buf_data equal to the model memory read at the src_addr issued 3 cycles earlier.
REQ-041 abort asserted on the 10th write of a 16x16 draw -> exactly 10 writes, IDLE one cycle later; start during the draw and a zero-size start are both no-ops.
REQ-042 rst_n pulsed low mid-draw -> frame_buf_we drops immediately and done=1; a new start after release draws correctly from pixel (0,0).
